axi_led_ctrl_m: RTL and testbench

//  AXI3 slave (PS7 M_AXI_GP port profile) exposing a small register file that drives LED_W LEDs.

---
 rtl/axi_led_ctrl_m.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_axi_led_ctrl_m.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_led_ctrl_m.sv
// AXI3 slave register file (CTRL/VALUE/PERIOD/ID) driving LED_W LEDs in
// static, blink or rotate-left mode, advanced by a programmable tick.
module axi_led_ctrl_m #(
  parameter int unsigned      LED_W      = 8,
  parameter logic [LED_W-1:0] RESET_PAT  = LED_W'(8'h55),
  parameter int unsigned      PRESCALE_W = 24,
  parameter int unsigned      ID_W       = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_AWVALID,
  input  logic [ID_W-1:0]       i_AWID,
  input  logic [31:0]           i_AWADDR,
  input  logic [3:0]            i_AWLEN,
  output logic                  o_AWREADY,
  input  logic                  i_WVALID,
  input  logic [ID_W-1:0]       i_WID,
  input  logic [31:0]           i_WDATA,
  input  logic [3:0]            i_WSTRB,
  input  logic                  i_WLAST,
  output logic                  o_WREADY,
  output logic                  o_BVALID,
  output logic [ID_W-1:0]       o_BID,
  output logic [1:0]            o_BRESP,
  input  logic                  i_BREADY,
  input  logic                  i_ARVALID,
  input  logic [ID_W-1:0]       i_ARID,
  input  logic [31:0]           i_ARADDR,
  input  logic [3:0]            i_ARLEN,
  output logic                  o_ARREADY,
  output logic                  o_RVALID,
  output logic [ID_W-1:0]       o_RID,
  output logic [31:0]           o_RDATA,
  output logic [1:0]            o_RRESP,
  output logic                  o_RLAST,
  input  logic                  i_RREADY,
  output logic [LED_W-1:0]      o_led
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VAL      = 32'h1ED0_0000 | 32'(LED_W);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] p);
    return (p << 1) | (p >> (LED_W - 1));
  endfunction

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic [ID_W-1:0] awid_q, awid_d, rid_q, rid_d;
  logic [9:0] waddr_q, waddr_d;
  logic wfirst_q, wfirst_d, werr_q, werr_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0] rbeat_q, rbeat_d;
  logic [31:0] rdata_q, rdata_d, rd_word_s;
  logic rd_hit_s, reg_we_s, wr_ctrl_s, wr_value_s, wr_period_s, tick_s;
  logic [1:0] mode_q, mode_d;
  logic [LED_W-1:0] value_q, value_d, pat_q, pat_d, led_q, led_d;
  logic [PRESCALE_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic phase_q, phase_d;
  logic unused_s;

  wire aw_hs_s = awready_q & i_AWVALID;
  wire w_hs_s  = wready_q & i_WVALID;
  wire b_hs_s  = bvalid_q & i_BREADY;
  wire ar_hs_s = arready_q & i_ARVALID;
  wire r_hs_s  = rvalid_q & i_RREADY;

  assign unused_s = ^{i_AWADDR[31:12], i_AWADDR[1:0], i_ARADDR[31:12], i_ARADDR[1:0], i_WID};

  // Write channel FSM: address latch, beat-0 register write, drain, response
  always_comb begin
    wstate_d = wstate_q;
    awid_d   = awid_q;
    waddr_d  = waddr_q;
    wfirst_d = wfirst_q;
    werr_d   = werr_q;
    reg_we_s = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          awid_d   = i_AWID;
          waddr_d  = i_AWADDR[11:2];
          wfirst_d = 1'b1;
          werr_d   = (i_AWLEN != 4'd0) || (i_AWADDR[11:2] > 10'd3);
          wstate_d = W_DATA;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          reg_we_s = wfirst_q;
          wfirst_d = 1'b0;
          if (i_WLAST) wstate_d = W_RESP;
          else         wstate_d = W_DATA;
        end else begin
          wstate_d = W_DATA;
        end
      end
      W_RESP: begin
        if (b_hs_s) wstate_d = W_IDLE;
        else        wstate_d = W_RESP;
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
    bvalid_d  = (wstate_d == W_RESP);
    bresp_d   = ((wstate_d == W_RESP) && werr_d) ? RESP_SLVERR : RESP_OKAY;
  end

  // Register file and LED engine; o_led is computed from next-state values
  always_comb begin
    wr_ctrl_s   = reg_we_s && (waddr_q == 10'd0);
    wr_value_s  = reg_we_s && (waddr_q == 10'd1);
    wr_period_s = reg_we_s && (waddr_q == 10'd2);
    if (wr_ctrl_s) mode_d = 2'(merge_strb({30'd0, mode_q}, i_WDATA, i_WSTRB));
    else           mode_d = mode_q;
    if (wr_value_s) value_d = LED_W'(merge_strb(32'(value_q), i_WDATA, i_WSTRB));
    else            value_d = value_q;
    if (wr_period_s) period_d = PRESCALE_W'(merge_strb(32'(period_q), i_WDATA, i_WSTRB));
    else             period_d = period_q;
    tick_s = (cnt_q == period_q);
    if (wr_ctrl_s || wr_period_s) begin
      cnt_d   = {PRESCALE_W{1'b0}};
      phase_d = 1'b0;
      pat_d   = value_d;
    end else begin
      if (tick_s) cnt_d = {PRESCALE_W{1'b0}};
      else        cnt_d = cnt_q + PRESCALE_W'(1);
      // A register write in the tick cycle swallows that tick's effect
      if (wr_value_s) begin
        phase_d = phase_q;
        pat_d   = value_d;
      end else if (tick_s) begin
        phase_d = ~phase_q;
        pat_d   = rotl1(pat_q);
      end else begin
        phase_d = phase_q;
        pat_d   = pat_q;
      end
    end
    case (mode_d)
      2'd1:    led_d = phase_d ? {LED_W{1'b0}} : value_d;
      2'd2:    led_d = pat_d;
      default: led_d = value_d;
    endcase
  end

  // Read channel FSM: sample register at AR handshake, then emit ARLEN+1 beats
  always_comb begin
    case (i_ARADDR[11:2])
      10'd0:   begin rd_word_s = {30'd0, mode_q};  rd_hit_s = 1'b1; end
      10'd1:   begin rd_word_s = 32'(value_q);     rd_hit_s = 1'b1; end
      10'd2:   begin rd_word_s = 32'(period_q);    rd_hit_s = 1'b1; end
      10'd3:   begin rd_word_s = ID_VAL;           rd_hit_s = 1'b1; end
      default: begin rd_word_s = 32'd0;            rd_hit_s = 1'b0; end
    endcase
    rstate_d = rstate_q;
    rid_d    = rid_q;
    rbeat_d  = rbeat_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rid_d    = i_ARID;
          rbeat_d  = i_ARLEN;
          rdata_d  = rd_word_s;
          rresp_d  = ((i_ARLEN != 4'd0) || !rd_hit_s) ? RESP_SLVERR : RESP_OKAY;
          rstate_d = R_DATA;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs_s) begin
          rdata_d = 32'd0;
          if (rbeat_q == 4'd0) begin
            rresp_d  = RESP_OKAY;
            rstate_d = R_IDLE;
          end else begin
            rbeat_d  = rbeat_q - 4'd1;
            rstate_d = R_DATA;
          end
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
    rlast_d   = rvalid_d && (rbeat_d == 4'd0);
  end

  // Write-side state and response flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wstate_q  <= W_IDLE;
      awid_q    <= {ID_W{1'b0}};
      waddr_q   <= 10'd0;
      wfirst_q  <= 1'b0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wfirst_q  <= wfirst_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read-side state and data flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rstate_q  <= R_IDLE;
      rid_q     <= {ID_W{1'b0}};
      rbeat_q   <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      rid_q     <= rid_d;
      rbeat_q   <= rbeat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Registers, tick counter and LED output flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q   <= 2'd0;
      value_q  <= RESET_PAT;
      period_q <= {PRESCALE_W{1'b0}};
      cnt_q    <= {PRESCALE_W{1'b0}};
      phase_q  <= 1'b0;
      pat_q    <= RESET_PAT;
      led_q    <= RESET_PAT;
    end else begin
      mode_q   <= mode_d;
      value_q  <= value_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      pat_q    <= pat_d;
      led_q    <= led_d;
    end
  end

  assign o_AWREADY = awready_q;
  assign o_WREADY  = wready_q;
  assign o_BVALID  = bvalid_q;
  assign o_BID     = awid_q;
  assign o_BRESP   = bresp_q;
  assign o_ARREADY = arready_q;
  assign o_RVALID  = rvalid_q;
  assign o_RID     = rid_q;
  assign o_RDATA   = rdata_q;
  assign o_RRESP   = rresp_q;
  assign o_RLAST   = rlast_q;
  assign o_led     = led_q;

endmodule

// File: tb/tb_axi_led_ctrl_m.sv
// Directed plus randomized bench for axi_led_ctrl_m against a cycle-level
// behavioural model of the register map and LED engine.
module tb_axi_led_ctrl_m;
  localparam int ID_W = 12;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_AWVALID, i_WVALID, i_WLAST, i_BREADY, i_ARVALID, i_RREADY;
  logic [ID_W-1:0] i_AWID, i_WID, i_ARID;
  logic [31:0] i_AWADDR, i_WDATA, i_ARADDR;
  logic [3:0] i_AWLEN, i_WSTRB, i_ARLEN;
  logic o_AWREADY, o_WREADY, o_BVALID, o_ARREADY, o_RVALID, o_RLAST;
  logic [ID_W-1:0] o_BID, o_RID;
  logic [1:0] o_BRESP, o_RRESP;
  logic [31:0] o_RDATA;
  logic [7:0] o_led;

  int n_assert = 0;
  int n_fail = 0;

  // behavioural model state
  logic [1:0] m_mode;
  logic [7:0] m_value, m_pat;
  logic [23:0] m_period, m_cnt;
  logic m_phase;
  logic mw_req = 1'b0;
  logic [31:0] mw_addr, mw_data;
  logic [3:0] mw_strb;
  logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h10};

  always #5 i_clk = ~i_clk;

  axi_led_ctrl_m dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_AWVALID(i_AWVALID), .i_AWID(i_AWID), .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN),
    .o_AWREADY(o_AWREADY),
    .i_WVALID(i_WVALID), .i_WID(i_WID), .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WLAST(i_WLAST),
    .o_WREADY(o_WREADY),
    .o_BVALID(o_BVALID), .o_BID(o_BID), .o_BRESP(o_BRESP), .i_BREADY(i_BREADY),
    .i_ARVALID(i_ARVALID), .i_ARID(i_ARID), .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN),
    .o_ARREADY(o_ARREADY),
    .o_RVALID(o_RVALID), .o_RID(o_RID), .o_RDATA(o_RDATA), .o_RRESP(o_RRESP),
    .o_RLAST(o_RLAST), .i_RREADY(i_RREADY),
    .o_led(o_led)
  );

  function automatic logic [31:0] bytes_en(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = strb[i/8] ? new_v[i] : old_v[i];
    return r;
  endfunction

  function automatic logic [7:0] exp_led();
    if (m_mode == 2'd1) return m_phase ? 8'h00 : m_value;
    if (m_mode == 2'd2) return m_pat;
    return m_value;
  endfunction

  function automatic logic [31:0] exp_reg(input logic [31:0] a);
    case (a[11:2])
      10'd0:   return {30'd0, m_mode};
      10'd1:   return {24'd0, m_value};
      10'd2:   return {8'd0, m_period};
      10'd3:   return 32'h1ED0_0008;
      default: return 32'd0;
    endcase
  endfunction

  // Model: register writes land at the W beat edge; a tick every PERIOD+1 cycles
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_mode <= 2'd0; m_value <= 8'h55; m_pat <= 8'h55;
      m_period <= 24'd0; m_cnt <= 24'd0; m_phase <= 1'b0;
    end else begin : mdl
      logic clr, vwr, tick;
      logic [7:0] nv;
      logic [15:0] dbl;
      clr = 1'b0; vwr = 1'b0; nv = m_value;
      tick = (m_cnt == m_period);
      if (mw_req) begin
        case (mw_addr[11:2])
          10'd0: begin m_mode <= 2'(bytes_en({30'd0, m_mode}, mw_data, mw_strb)); clr = 1'b1; end
          10'd1: begin nv = 8'(bytes_en({24'd0, m_value}, mw_data, mw_strb)); m_value <= nv; vwr = 1'b1; end
          10'd2: begin m_period <= 24'(bytes_en({8'd0, m_period}, mw_data, mw_strb)); clr = 1'b1; end
          default: ;
        endcase
      end
      if (clr) begin
        m_cnt <= 24'd0; m_phase <= 1'b0; m_pat <= m_value;
      end else begin
        m_cnt <= tick ? 24'd0 : m_cnt + 24'd1;
        if (vwr) m_pat <= nv;
        else if (tick) begin
          m_phase <= ~m_phase;
          dbl = {m_pat, m_pat} << 1;
          m_pat <= dbl[15:8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    chk("led", {24'd0, o_led}, {24'd0, exp_led()});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [3:0] len, input logic [ID_W-1:0] id);
    int g;
    i_AWVALID = 1'b1; i_AWADDR = addr; i_AWLEN = len; i_AWID = id;
    g = 0;
    while (!o_AWREADY && g < 50) begin step(); g++; end
    chk("aw_wait", 32'(g < 50), 32'd1);
    step();
    i_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      i_WVALID = 1'b1; i_WID = id; i_WLAST = (b == int'(len));
      i_WDATA = (b == 0) ? data : $urandom;
      i_WSTRB = (b == 0) ? strb : 4'hF;
      g = 0;
      while (!o_WREADY && g < 50) begin step(); g++; end
      chk("w_wait", 32'(g < 50), 32'd1);
      if (b == 0) begin mw_req = 1'b1; mw_addr = addr; mw_data = data; mw_strb = strb; end
      step();
      mw_req = 1'b0;
    end
    i_WVALID = 1'b0; i_WLAST = 1'b0;
    g = 0;
    while (!o_BVALID && g < 50) begin step(); g++; end
    chk("b_wait", 32'(g < 50), 32'd1);
    chk("bresp", {30'd0, o_BRESP}, ((len != 4'd0) || (addr[11:2] > 10'd3)) ? 32'd2 : 32'd0);
    chk("bid", 32'(o_BID), 32'(id));
    i_BREADY = 1'b1;
    step();
    i_BREADY = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [3:0] len, input logic [ID_W-1:0] id,
                    input logic rand_ready);
    int g, beat;
    logic [31:0] exp0, eresp;
    exp0 = exp_reg(addr);
    eresp = ((len != 4'd0) || (addr[11:2] > 10'd3)) ? 32'd2 : 32'd0;
    i_ARVALID = 1'b1; i_ARADDR = addr; i_ARLEN = len; i_ARID = id;
    g = 0;
    while (!o_ARREADY && g < 50) begin step(); g++; end
    chk("ar_wait", 32'(g < 50), 32'd1);
    step();
    i_ARVALID = 1'b0;
    beat = 0; g = 0;
    while (beat <= int'(len) && g < 200) begin
      chk("rvalid", 32'(o_RVALID), 32'd1);
      chk("rdata", o_RDATA, (beat == 0) ? exp0 : 32'd0);
      chk("rresp", {30'd0, o_RRESP}, eresp);
      chk("rlast", 32'(o_RLAST), 32'(beat == int'(len)));
      chk("rid", 32'(o_RID), 32'(id));
      i_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (i_RREADY) beat++;
      g++;
    end
    chk("r_budget", 32'(g < 200), 32'd1);
    i_RREADY = 1'b0;
    chk("rvalid_end", 32'(o_RVALID), 32'd0);
  endtask

  initial begin
    int g;
    logic [31:0] a, d;
    logic [3:0] l;
    i_rst_n = 1'b0;
    i_AWVALID = 1'b0; i_WVALID = 1'b0; i_WLAST = 1'b0; i_BREADY = 1'b0;
    i_ARVALID = 1'b0; i_RREADY = 1'b0;
    i_AWID = '0; i_WID = '0; i_ARID = '0; i_AWADDR = '0; i_WDATA = '0; i_ARADDR = '0;
    i_AWLEN = '0; i_WSTRB = '0; i_ARLEN = '0;
    repeat (3) step();
    chk("rst_led", {24'd0, o_led}, 32'h55);
    chk("rst_awready", 32'(o_AWREADY), 32'd0);
    chk("rst_arready", 32'(o_ARREADY), 32'd0);
    i_rst_n = 1'b1;
    step();
    chk("rel_awready", 32'(o_AWREADY), 32'd1);
    chk("rel_arready", 32'(o_ARREADY), 32'd1);
    chk("rel_bvalid", 32'(o_BVALID), 32'd0);
    chk("rel_rvalid", 32'(o_RVALID), 32'd0);

    wr(32'h4, 32'h0000_00A5, 4'h1, 4'd0, 12'h123);
    chk("led_a5", {24'd0, o_led}, 32'hA5);
    rd(32'h4, 4'd0, 12'h045, 1'b0);

    wr(32'h8, 32'd3, 4'hF, 4'd0, 12'h001);
    wr(32'h0, 32'd2, 4'hF, 4'd0, 12'h002);
    wr(32'h4, 32'h81, 4'hF, 4'd0, 12'h003);
    repeat (14) step();
    wr(32'h0, 32'd1, 4'hF, 4'd0, 12'h004);
    chk("blink_start", {24'd0, o_led}, 32'h81);
    repeat (12) step();

    wr(32'h0, 32'd0, 4'hF, 4'd0, 12'h005);
    wr(32'h4, 32'h0000_003C, 4'hF, 4'd3, 12'hABC);
    chk("burst_led", {24'd0, o_led}, 32'h3C);
    rd(32'h4, 4'd0, 12'h006, 1'b0);

    rd(32'hC, 4'd2, 12'h7E1, 1'b1);
    rd(32'h40, 4'd0, 12'h7E2, 1'b0);

    for (int it = 0; it < 30; it++) begin
      a = addrs[$urandom_range(0, 5)] | ($urandom & 32'hFFFF_F003);
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      d = (a[11:2] == 10'd2) ? 32'($urandom_range(0, 5)) : $urandom;
      case ($urandom_range(0, 2))
        0:       wr(a, d, 4'($urandom_range(0, 15)), l, 12'($urandom));
        1:       rd(a, l, 12'($urandom), 1'b1);
        default: repeat ($urandom_range(1, 8)) step();
      endcase
    end

    i_AWVALID = 1'b1; i_AWADDR = 32'h4; i_AWLEN = 4'd0; i_AWID = 12'h321;
    g = 0;
    while (!o_AWREADY && g < 50) begin step(); g++; end
    chk("aw_wait_rst", 32'(g < 50), 32'd1);
    step();
    i_AWVALID = 1'b0;
    chk("wready_pre_rst", 32'(o_WREADY), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_led", {24'd0, o_led}, 32'h55);
    chk("mid_awready", 32'(o_AWREADY), 32'd0);
    chk("mid_wready", 32'(o_WREADY), 32'd0);
    chk("mid_bvalid", 32'(o_BVALID), 32'd0);
    chk("mid_bresp", {30'd0, o_BRESP}, 32'd0);
    chk("mid_arready", 32'(o_ARREADY), 32'd0);
    chk("mid_rvalid", 32'(o_RVALID), 32'd0);
    chk("mid_rlast", 32'(o_RLAST), 32'd0);
    chk("mid_rdata", o_RDATA, 32'd0);
    chk("mid_rresp", {30'd0, o_RRESP}, 32'd0);
    step(); step();
    i_rst_n = 1'b1;
    step();
    chk("post_awready", 32'(o_AWREADY), 32'd1);
    rd(32'h4, 4'd0, 12'h00F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
